// File: rtl/axi_pcie_cmd_sequencer.sv
// Command sequencer feeding the PCIe AXI master VIO inputs: queues host commands,
// issues them one at a time with a START edge, and returns read data or timeout status.
module axi_pcie_cmd_sequencer #(
  parameter int CMD_DEPTH      = 4,
  parameter int START_GAP      = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_ops,
  input  logic [63:0]  cmd_addr,
  input  logic [255:0] cmd_wdata,
  input  logic [31:0]  cmd_wstrb,
  input  logic [87:0]  cmd_user,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_ops,
  output logic [255:0] rsp_rdata,
  output logic         rsp_timeout,
  output logic [63:0]  VIO_AXI_ADDR,
  output logic [255:0] VIO_AXI_WDATA,
  output logic [31:0]  VIO_AXI_WSTRB,
  output logic [87:0]  VIO_AXI_AWUSER,
  output logic         VIO_AXI_OPS,
  output logic         VIO_AXI_START,
  input  logic [7:0]   master_state,
  input  logic [255:0] VIO_AXI_RDATA,
  output logic         busy,
  output logic [15:0]  timeout_cnt
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 1 + 64 + 256 + 32 + 88;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(START_GAP + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_GAP} state_t;

  logic [EW-1:0] mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [EW-1:0] head;
  state_t        state;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;
  logic          push, pop, empty, gap_last, timer_last, idle_nxt;

  assign empty      = (wr_ptr == rd_ptr);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == S_IDLE) && !empty && !rsp_valid;
  assign wr_nxt     = wr_ptr + {{AW{1'b0}}, push};
  assign rd_nxt     = rd_ptr + {{AW{1'b0}}, pop};
  assign head       = mem[rd_ptr[AW-1:0]];
  assign gap_last   = (gap_cnt == GW'(START_GAP - 1));
  // >= rather than == so a timer that overshoots on the ISSUE->WAIT hop still expires
  assign timer_last = (timer >= TW'(TIMEOUT_CYCLES - 1));
  assign idle_nxt   = ((state == S_IDLE) && !pop) || ((state == S_GAP) && gap_last);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_ops, cmd_addr, cmd_wdata, cmd_wstrb, cmd_user};
  end

  // cmd_ready and busy are registered from next-cycle occupancy, so a pop frees a slot one cycle later
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      cmd_ready <= ((wr_nxt - rd_nxt) != PW'(CMD_DEPTH));
      busy      <= !idle_nxt || (wr_nxt != rd_nxt);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_GAP;
      timer          <= '0;
      gap_cnt        <= '0;
      VIO_AXI_ADDR   <= '0;
      VIO_AXI_WDATA  <= '0;
      VIO_AXI_WSTRB  <= '0;
      VIO_AXI_AWUSER <= '0;
      VIO_AXI_OPS    <= 1'b0;
      VIO_AXI_START  <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_ops        <= 1'b0;
      rsp_rdata      <= '0;
      rsp_timeout    <= 1'b0;
      timeout_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            {VIO_AXI_OPS, VIO_AXI_ADDR, VIO_AXI_WDATA, VIO_AXI_WSTRB, VIO_AXI_AWUSER} <= head;
            VIO_AXI_START <= 1'b1;
            timer         <= '0;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          timer <= timer + TW'(1);
          if ((state == S_ISSUE) && (master_state != 8'd0)) begin
            VIO_AXI_START <= 1'b0;
            state         <= S_WAIT;
          end else if ((state == S_WAIT) && (master_state == 8'd0)) begin
            rsp_valid   <= 1'b1;
            rsp_ops     <= VIO_AXI_OPS;
            rsp_rdata   <= VIO_AXI_OPS ? VIO_AXI_RDATA : 256'd0;
            rsp_timeout <= 1'b0;
            state       <= S_RESP;
          end else if (timer_last) begin
            VIO_AXI_START <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_ops       <= VIO_AXI_OPS;
            rsp_rdata     <= '0;
            rsp_timeout   <= 1'b1;
            if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
            state         <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            gap_cnt   <= '0;
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_last) state <= S_IDLE;
          else gap_cnt <= gap_cnt + GW'(1);
        end
        default: state <= S_GAP;
      endcase
    end
  end

endmodule
